// File: rtl/io_resp_pkg.sv
// Shared widths and the tagged FIFO word for the CPU I/O port responder.
package io_resp_pkg;
    localparam int DATA_W = 8;
    localparam int PORT_W = 2;
    localparam int NPORTS = 4;

    typedef struct packed {
        logic [PORT_W-1:0] port;
        logic [DATA_W-1:0] data;
    } tagged_byte_t;

    // Index of the lowest set bit; zero when none is set.
    function automatic logic [PORT_W-1:0] lowest_set(input logic [NPORTS-1:0] v);
        lowest_set = '0;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = PORT_W'(i);
        end
    endfunction
endpackage

// File: rtl/io_resp_fifo.sv
// Synchronous FIFO of tagged bytes with extra-bit pointer wrap; head is driven from
// registered storage only, so pop has no combinational path to the head word.
module io_resp_fifo
    import io_resp_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  tagged_byte_t push_data,
    input  logic         pop,
    output tagged_byte_t head,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(FIFO_DEPTH);

    tagged_byte_t   mem [FIFO_DEPTH];
    logic [AW:0]    wr_ptr_reg;
    logic [AW:0]    rd_ptr_reg;
    logic           push_ok;
    logic           pop_ok;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + {{AW{1'b0}}, 1'b1};
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + {{AW{1'b0}}, 1'b1};
        end
    end
endmodule

// File: rtl/io_port_responder.sv
// CPU strobed I/O port responder: output capture into a tagged FIFO, per-port input
// holding registers. Define IO_RESP_HOLD_EN to keep the last byte visible after consume.
module io_port_responder
    import io_resp_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] out_port_0,
    input  logic [DATA_W-1:0] out_port_1,
    input  logic [DATA_W-1:0] out_port_2,
    input  logic [DATA_W-1:0] out_port_3,
    input  logic [NPORTS-1:0] out_strobe,
    output logic [DATA_W-1:0] in_port_0,
    output logic [DATA_W-1:0] in_port_1,
    output logic [DATA_W-1:0] in_port_2,
    output logic [DATA_W-1:0] in_port_3,
    input  logic [NPORTS-1:0] in_strobe,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [DATA_W-1:0] tx_data,
    output logic [PORT_W-1:0] tx_port,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic [PORT_W-1:0] rx_port,
    output logic              overflow
);
    logic [NPORTS-1:0] os_q_reg;
    logic [NPORTS-1:0] is_q_reg;
    logic              armed_reg;
    logic [NPORTS-1:0] out_event;
    logic [NPORTS-1:0] in_event;
    logic              multi_event;
    logic [PORT_W-1:0] cap_port;
    tagged_byte_t      push_word;
    tagged_byte_t      head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              overflow_reg;

    logic [DATA_W-1:0] out_port_arr  [NPORTS];
    logic [DATA_W-1:0] in_port_arr   [NPORTS];
    logic [DATA_W-1:0] hold_data_reg [NPORTS];
    logic              hold_v_reg    [NPORTS];
    logic              load_v        [NPORTS];

    assign out_port_arr[0] = out_port_0;
    assign out_port_arr[1] = out_port_1;
    assign out_port_arr[2] = out_port_2;
    assign out_port_arr[3] = out_port_3;
    assign in_port_0 = in_port_arr[0];
    assign in_port_1 = in_port_arr[1];
    assign in_port_2 = in_port_arr[2];
    assign in_port_3 = in_port_arr[3];

    // The detectors restart idle-high but need one settled sample before they may
    // report, so a strobe already low when reset releases is not taken as an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            os_q_reg  <= '1;
            is_q_reg  <= '1;
            armed_reg <= 1'b0;
        end else begin
            os_q_reg  <= out_strobe;
            is_q_reg  <= in_strobe;
            armed_reg <= 1'b1;
        end
    end

    assign out_event   = armed_reg ? (~out_strobe & os_q_reg) : '0;
    assign in_event    = armed_reg ? (~in_strobe & is_q_reg) : '0;
    assign multi_event = |(out_event & (out_event - NPORTS'(1)));
    assign cap_port    = lowest_set(out_event);
    assign push_word   = '{port: cap_port, data: out_port_arr[cap_port]};
    assign pop         = tx_valid && tx_ready;

    io_resp_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (|out_event),
        .push_data (push_word),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign tx_valid = !fifo_empty;
    assign tx_data  = head.data;
    assign tx_port  = head.port;

    always_ff @(posedge clk) begin
        if (reset) overflow_reg <= 1'b0;
        else if (multi_event || ((|out_event) && fifo_full && !pop)) overflow_reg <= 1'b1;
    end
    assign overflow = overflow_reg;

    assign rx_ready = !hold_v_reg[rx_port] || in_event[rx_port];

    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_hold
            assign load_v[gi] = rx_valid && rx_ready && (rx_port == PORT_W'(gi));

            // Load beats consume when both land on the same edge.
            always_ff @(posedge clk) begin
                if (reset) begin
                    hold_v_reg[gi]    <= 1'b0;
                    hold_data_reg[gi] <= '0;
                end else if (load_v[gi]) begin
                    hold_v_reg[gi]    <= 1'b1;
                    hold_data_reg[gi] <= rx_data;
                end else if (in_event[gi]) begin
                    hold_v_reg[gi]    <= 1'b0;
                end
            end

`ifdef IO_RESP_HOLD_EN
            assign in_port_arr[gi] = hold_data_reg[gi];
`else
            assign in_port_arr[gi] = hold_v_reg[gi] ? hold_data_reg[gi] : '0;
`endif
        end
    endgenerate
endmodule

// File: doc/io_port_responder.md
# io_port_responder

Peripheral-side responder for the CPU's four-port strobed I/O interface. It captures every byte the CPU writes with OUTPUT into a tagged FIFO that a downstream host drains with valid/ready. It also supplies per-port holding registers that the host fills with valid/ready and the CPU consumes with INPUT. It sits between the CPU's `in_port_*`/`out_port_*`/strobe pins and the system-side byte streams.

## Interface
- `FIFO_DEPTH`, 8, output FIFO entries; power of two, minimum 2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `out_port_0..3`  in  8  CPU output port data.
- `out_strobe`  in  4  CPU output strobes; active-low, one-cycle pulse per OUTPUT.
- `in_port_0..3`  out  8  data presented to the CPU input ports.
- `in_strobe`  in  4  CPU input strobes; active-low pulse, issued after the CPU has sampled the port.
- `tx_valid` / `tx_ready`  out / in  1  output-stream handshake.
- `tx_data`  out  8  captured byte.
- `tx_port`  out  2  port index the byte was written to.
- `rx_valid` / `rx_ready`  in / out  1  input-stream handshake.
- `rx_data`  in  8  byte for a CPU input port.
- `rx_port`  in  2  target input port.
- `overflow`  out  1  sticky; a captured byte was lost.

## Operation
- Strobe detection: registers `os_q[3:0]` and `is_q[3:0]` hold the previous strobe values and reset to 4'b1111. An event on bit i is `strobe[i]==0 && q[i]==1` (falling edge). A strobe held low produces exactly one event.
- Output capture: on an output event, push `{i, out_port_i}` into the FIFO.
  - If more than one output event occurs in the same cycle, only the lowest index is pushed, and `overflow` is set.
  - If the FIFO is full and no pop occurs that cycle, the byte is dropped and `overflow` is set.
  - If the FIFO is full and a pop occurs in the same cycle, the push is accepted.
- Output drain: `tx_valid` is high whenever the FIFO is not empty. `tx_data`/`tx_port` show the head entry. The head pops on `tx_valid && tx_ready`.
- Input holding: each port has `hold_data[i]` and `hold_v[i]`. `in_port_i = hold_v[i] ? hold_data[i] : 8'h00`.
- Input consumption: an input event on port i clears `hold_v[i]`.
- Input load: `rx_ready = !hold_v[rx_port] || in_event[rx_port]`. On `rx_valid && rx_ready`, the block loads `hold_data[rx_port]` and sets `hold_v[rx_port]`.
- Simultaneous consume and load on the same port: the load wins, and the new byte is valid after the edge.
- Simultaneous input events on several ports are all consumed; there is no priority on the input side.
- `overflow` clears only on reset.
- Reset values:
  - FIFO empty; `tx_valid`=0, `tx_data`=0, `tx_port`=0.
  - `hold_v`=0 and `hold_data`=0, so all `in_port_*`=0.
  - `rx_ready`=1, `overflow`=0.
- Reset mid-operation discards all FIFO contents and all held bytes, and rearms edge detection to idle-high.

## Timing
- Capture latency: the strobe is seen low at edge N, the entry is written at edge N, and `tx_valid` is high from N+1.
- The pushed byte is `out_port_i` as sampled at edge N. The CPU holds it stable through the pulse.
- Input path: a byte accepted at edge N appears on `in_port_i` from N+1. After the consume event at edge M, `in_port_i` shows 0 from M+1.
- The FIFO is fall-through-free: data is registered and there is no combinational path from `tx_ready` to `tx_data`.
- `rx_ready` is combinational from `rx_port`, `hold_v` and the strobe inputs.
- Sustained throughput: one push and one pop per cycle.

## Configuration
- `IO_RESP_HOLD_EN`
  - Defined: an input event does not zero `in_port_i`. The port keeps showing the last byte, and `hold_v` still clears so `rx_ready` reopens.
  - Undefined: `in_port_i` reads 8'h00 whenever `hold_v[i]`=0.

## Structure
- `io_resp_pkg`: `DATA_W`=8, `PORT_W`=2, `NPORTS`=4, and the packed struct `tagged_byte_t {port, data}` used as the FIFO word.
- Sub-module `io_resp_fifo`: synchronous FIFO of `tagged_byte_t`, parameterised by `FIFO_DEPTH`. It has push/pop/full/empty and uses extra-bit pointer wrap.
- The top level holds the edge detectors, the capture arbitration and the four holding registers.

## Test plan
- Output capture: pulse `out_strobe`=4'b1101 for one cycle with `out_port_1`=8'hA5 and `tx_ready`=1. Expect `tx_valid` one cycle later with `tx_port`=1, `tx_data`=8'hA5, then the FIFO empty.
- Full FIFO: with `tx_ready`=0, issue 9 single-cycle pulses on port 0 with data 0..8. Expect 8 entries, data 0..7, and `overflow`=1. Draining yields 0..7 only.
- Simultaneous output events: one cycle with `out_strobe`=4'b0110 (ports 0 and 3). Expect only port 0 pushed and `overflow`=1. Holding `out_strobe` low for 5 cycles yields exactly one entry.
- Input path: push `rx_port`=2, `rx_data`=8'h3C. Expect `in_port_2`=8'h3C next cycle and `rx_ready` low for port 2. After an `in_strobe[2]` pulse, `in_port_2` reads 8'h00 (or 8'h3C with `IO_RESP_HOLD_EN`) and `rx_ready` returns high.
- Same-cycle consume and load: `in_strobe[2]` pulse coincident with `rx_valid` carrying 8'h77 for port 2. Expect `in_port_2`=8'h77 and `hold_v[2]`=1.
- Reset mid-stream: with 3 FIFO entries and 2 held bytes, assert `reset` for one cycle. Expect `tx_valid`=0, all `in_port_*`=0, `overflow`=0, and a strobe already low at release produces no event.
